// File: rtl/divider_taint_pkg.sv
// Shared types and sizing helpers for the taint-tracking sequential divider.
package divider_taint_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int DEFAULT_WIDTH = 4;

  // Iteration counter runs 0..w-1.
  function automatic int cnt_w(input int w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/divider_taint_step.sv
// One combinational restoring-division step on {rem, quo}, data plus taint.
// DIVIDER_PRECISE_TAINT_EN selects per-bit taint propagation; otherwise taint is coarse.
module divider_taint_step #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] rem_t,
  input  logic [WIDTH-1:0] quo_t,
  input  logic [WIDTH-1:0] divisor,
  input  logic [WIDTH-1:0] divisor_t,
  output logic [WIDTH-1:0] rem_n,
  output logic [WIDTH-1:0] quo_n,
  output logic [WIDTH-1:0] rem_t_n,
  output logic [WIDTH-1:0] quo_t_n
);

  logic [WIDTH:0]   rem_s;
  logic [WIDTH-1:0] diff;
  logic             ge;

  // rem_s is WIDTH+1 bits so the shifted-out remainder MSB still counts in the compare.
  assign rem_s = {rem, quo[WIDTH-1]};
  assign ge    = rem_s[WIDTH] | (rem_s[WIDTH-1:0] >= divisor);
  assign diff  = rem_s[WIDTH-1:0] - divisor;
  assign rem_n = ge ? diff : rem_s[WIDTH-1:0];
  assign quo_n = (quo << 1) | WIDTH'(ge);

`ifdef DIVIDER_PRECISE_TAINT_EN
  logic [WIDTH:0] rem_t_s;
  logic           cmp_t;

  assign rem_t_s = {rem_t, quo_t[WIDTH-1]};
  assign cmp_t   = (|divisor_t) | (|rem_t_s);
  assign quo_t_n = (quo_t << 1) | WIDTH'(cmp_t);
  assign rem_t_n = rem_t_s[WIDTH-1:0] | divisor_t | {WIDTH{cmp_t}};
`else
  // Coarse taint is uniform across the word, so it only needs to stay sticky.
  assign quo_t_n = quo_t | divisor_t;
  assign rem_t_n = rem_t | divisor_t;
`endif

endmodule

// File: rtl/sequential_divider_tainttrack.sv
// Restoring sequential divider (IDLE/CALC/DONE) with taint tracking on every result.
// Define DIVIDER_PRECISE_TAINT_EN for per-step taint propagation instead of coarse word taint.
module sequential_divider_tainttrack
  import divider_taint_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             start_t,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] dividend_t,
  input  logic [WIDTH-1:0] divisor,
  input  logic [WIDTH-1:0] divisor_t,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] quotient_t,
  output logic [WIDTH-1:0] remainder,
  output logic [WIDTH-1:0] remainder_t,
  output logic             div_by_zero,
  output logic             div_by_zero_t
);

  localparam int CW = cnt_w(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] rem, quo, rem_t, quo_t, dvs, dvs_t;
  logic [WIDTH-1:0] rem_n, quo_n, rem_t_n, quo_t_n;
  logic             tflag;
  logic [WIDTH-1:0] ld_quo_t, ld_rem_t, zd_quo_t, zd_rem_t;

`ifdef DIVIDER_PRECISE_TAINT_EN
  assign ld_quo_t = dividend_t;
  assign ld_rem_t = '0;
  assign zd_quo_t = {WIDTH{|divisor_t}};
  assign zd_rem_t = dividend_t;
`else
  logic t_in;
  assign t_in     = (|dividend_t) | (|divisor_t) | start_t;
  assign ld_quo_t = {WIDTH{t_in}};
  assign ld_rem_t = {WIDTH{t_in}};
  assign zd_quo_t = {WIDTH{t_in}};
  assign zd_rem_t = {WIDTH{t_in}};
`endif

  divider_taint_step #(.WIDTH(WIDTH)) u_step (
    .rem       (rem),
    .quo       (quo),
    .rem_t     (rem_t),
    .quo_t     (quo_t),
    .divisor   (dvs),
    .divisor_t (dvs_t),
    .rem_n     (rem_n),
    .quo_n     (quo_n),
    .rem_t_n   (rem_t_n),
    .quo_t_n   (quo_t_n)
  );

  // A tainted start poisons every taint output of that operation.
  assign quotient    = quo;
  assign remainder   = rem;
  assign quotient_t  = quo_t | {WIDTH{tflag}};
  assign remainder_t = rem_t | {WIDTH{tflag}};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      cnt           <= '0;
      rem           <= '0;
      quo           <= '0;
      rem_t         <= '0;
      quo_t         <= '0;
      dvs           <= '0;
      dvs_t         <= '0;
      tflag         <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      div_by_zero   <= 1'b0;
      div_by_zero_t <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            cnt           <= '0;
            dvs           <= divisor;
            dvs_t         <= divisor_t;
            tflag         <= start_t;
            div_by_zero_t <= (|divisor_t) | start_t;
            busy          <= 1'b1;
            if (divisor == '0) begin
              quo         <= '1;
              rem         <= dividend;
              quo_t       <= zd_quo_t;
              rem_t       <= zd_rem_t;
              div_by_zero <= 1'b1;
              done        <= 1'b1;
              state       <= DONE;
            end else begin
              quo         <= dividend;
              rem         <= '0;
              quo_t       <= ld_quo_t;
              rem_t       <= ld_rem_t;
              div_by_zero <= 1'b0;
              state       <= CALC;
            end
          end
        end
        CALC: begin
          quo   <= quo_n;
          rem   <= rem_n;
          quo_t <= quo_t_n;
          rem_t <= rem_t_n;
          cnt   <= cnt + 1'b1;
          if (cnt == LAST) begin
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sequential_divider_tainttrack.sv
// Directed checks for sequential_divider_tainttrack at WIDTH=4.
module tb_sequential_divider_tainttrack;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n, start, start_t;
  logic [W-1:0] dividend, dividend_t, divisor, divisor_t;
  logic         busy, done, div_by_zero, div_by_zero_t;
  logic [W-1:0] quotient, quotient_t, remainder, remainder_t;

  int checks = 0;
  int errors = 0;

  sequential_divider_tainttrack #(.WIDTH(W)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .start_t       (start_t),
    .dividend      (dividend),
    .dividend_t    (dividend_t),
    .divisor       (divisor),
    .divisor_t     (divisor_t),
    .busy          (busy),
    .done          (done),
    .quotient      (quotient),
    .quotient_t    (quotient_t),
    .remainder     (remainder),
    .remainder_t   (remainder_t),
    .div_by_zero   (div_by_zero),
    .div_by_zero_t (div_by_zero_t)
  );

  always #5 clk = ~clk;

  // Present a start for one cycle; returns 1ns after the accepting edge.
  task automatic do_start(input logic [W-1:0] dd, input logic [W-1:0] ds,
                          input logic [W-1:0] ddt, input logic [W-1:0] dst, input logic st);
    @(negedge clk);
    dividend = dd; divisor = ds; dividend_t = ddt; divisor_t = dst; start_t = st; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; start_t = 1'b0;
  endtask

  // Advance edges until done or budget runs out; returns edges consumed.
  task automatic wait_done(output int n);
    n = 0;
    while (done !== 1'b1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 0; start_t = 0;
    dividend = 0; dividend_t = 0; divisor = 0; divisor_t = 0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({busy, done, div_by_zero, div_by_zero_t, quotient, quotient_t, remainder, remainder_t} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got busy=%0b done=%0b q=%h qt=%h r=%h rt=%h dbz=%0b dbzt=%0b want all 0",
               busy, done, quotient, quotient_t, remainder, remainder_t, div_by_zero, div_by_zero_t);
    end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_basic;
    int n;
    do_start(4'd13, 4'd3, 4'd0, 4'd0, 1'b0);
    checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      errors++; $display("FAIL basic_accept: got busy=%0b done=%0b want busy=1 done=0", busy, done);
    end
    wait_done(n);
    checks++;
    if (n !== 4) begin errors++; $display("FAIL basic_latency: got %0d edges after accept want 4", n); end
    checks++;
    if (quotient !== 4'd4 || remainder !== 4'd1 || div_by_zero !== 1'b0) begin
      errors++; $display("FAIL basic_result: got q=%0d r=%0d dbz=%0b want q=4 r=1 dbz=0", quotient, remainder, div_by_zero);
    end
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || quotient !== 4'd4 || remainder !== 4'd1) begin
      errors++; $display("FAIL basic_hold: got done=%0b busy=%0b q=%0d r=%0d want 0 0 4 1", done, busy, quotient, remainder);
    end
  endtask

  task automatic test_div_zero;
    do_start(4'd7, 4'd0, 4'd0, 4'd0, 1'b0);
    checks++;
    if (done !== 1'b1 || busy !== 1'b1 || quotient !== 4'hF || remainder !== 4'd7 || div_by_zero !== 1'b1) begin
      errors++; $display("FAIL divzero_result: got done=%0b busy=%0b q=%h r=%0d dbz=%0b want 1 1 f 7 1",
                         done, busy, quotient, remainder, div_by_zero);
    end
    checks++;
    if (quotient_t !== 4'h0 || remainder_t !== 4'h0 || div_by_zero_t !== 1'b0) begin
      errors++; $display("FAIL divzero_taint: got qt=%h rt=%h dbzt=%0b want 0 0 0", quotient_t, remainder_t, div_by_zero_t);
    end
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || div_by_zero !== 1'b1) begin
      errors++; $display("FAIL divzero_after: got done=%0b busy=%0b dbz=%0b want 0 0 1", done, busy, div_by_zero);
    end
  endtask

  task automatic test_taint_force;
    int n;
    do_start(4'd9, 4'd2, 4'd0, 4'd0, 1'b1);
    checks++;
    if (div_by_zero !== 1'b0) begin errors++; $display("FAIL dbz_clear: got %0b want 0", div_by_zero); end
    wait_done(n);
    checks++;
    if (n !== 4 || quotient !== 4'd4 || remainder !== 4'd1) begin
      errors++; $display("FAIL force_result: got n=%0d q=%0d r=%0d want 4 4 1", n, quotient, remainder);
    end
    checks++;
    if (quotient_t !== 4'hF || remainder_t !== 4'hF || div_by_zero_t !== 1'b1) begin
      errors++; $display("FAIL force_taint: got qt=%h rt=%h dbzt=%0b want f f 1", quotient_t, remainder_t, div_by_zero_t);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_no_taint;
    int n;
    do_start(4'd15, 4'd15, 4'd0, 4'd0, 1'b0);
    wait_done(n);
    checks++;
    if (n !== 4 || quotient !== 4'd1 || remainder !== 4'd0) begin
      errors++; $display("FAIL equal_result: got n=%0d q=%0d r=%0d want 4 1 0", n, quotient, remainder);
    end
    checks++;
    if (quotient_t !== 4'h0 || remainder_t !== 4'h0 || div_by_zero_t !== 1'b0) begin
      errors++; $display("FAIL equal_taint: got qt=%h rt=%h dbzt=%0b want 0 0 0", quotient_t, remainder_t, div_by_zero_t);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_dividend_taint;
    int n;
    logic [W-1:0] exp_qt;
`ifdef DIVIDER_PRECISE_TAINT_EN
    exp_qt = 4'h1;
`else
    exp_qt = 4'hF;
`endif
    do_start(4'd13, 4'd3, 4'b0001, 4'd0, 1'b0);
    wait_done(n);
    checks++;
    if (quotient !== 4'd4 || quotient_t !== exp_qt || remainder_t !== 4'hF || div_by_zero_t !== 1'b0) begin
      errors++; $display("FAIL dividend_taint: got q=%0d qt=%h rt=%h dbzt=%0b want 4 %h f 0",
                         quotient, quotient_t, remainder_t, div_by_zero_t, exp_qt);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back;
    int pulses = 0;
    int at = -1;
    logic [W-1:0] q_at = '0, r_at = '0;
    do_start(4'd13, 4'd3, 4'd0, 4'd0, 1'b0);
    @(posedge clk); #1;
    @(negedge clk);
    dividend = 4'd6; divisor = 4'd2; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    // Edge 2 after accept has just passed; done is due on edge 4.
    for (int i = 3; i < 12; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1) begin pulses++; at = i; q_at = quotient; r_at = remainder; end
    end
    checks++;
    if (pulses !== 1 || at !== 4) begin
      errors++; $display("FAIL b2b_pulses: got %0d pulses at edge %0d want 1 at 4", pulses, at);
    end
    checks++;
    if (q_at !== 4'd4 || r_at !== 4'd1) begin
      errors++; $display("FAIL b2b_result: got q=%0d r=%0d want 4 1", q_at, r_at);
    end
  endtask

  task automatic test_reset_mid;
    int pulses = 0;
    int busy_seen = 0;
    do_start(4'd13, 4'd3, 4'd0, 4'd0, 1'b0);
    @(posedge clk); #1;
    @(negedge clk); rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, div_by_zero, div_by_zero_t, quotient, quotient_t, remainder, remainder_t} !== '0) begin
      errors++; $display("FAIL midreset_outputs: got busy=%0b done=%0b q=%h r=%h want all 0", busy, done, quotient, remainder);
    end
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1) pulses++;
      if (busy === 1'b1) busy_seen++;
    end
    checks++;
    if (pulses !== 0 || busy_seen !== 0) begin
      errors++; $display("FAIL midreset_quiet: got %0d done pulses %0d busy cycles want 0 0", pulses, busy_seen);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_div_zero();
    test_taint_force();
    test_no_taint();
    test_dividend_taint();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
